// File: rtl/regfile_exec_unit.sv
// Execute/write-back sequencer for a 16x32 two-read/one-write register file.
// One op at a time: READ -> CAPT -> (MUL iterations) -> WB, or straight to WB/ERR.
module regfile_exec_unit #(
    parameter int DW       = 32,
    parameter int AW       = 4,
    parameter int MUL_ITER = 32
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [3:0]    req_op,
    input  logic [AW-1:0] req_rd,
    input  logic [AW-1:0] req_rs1,
    input  logic [AW-1:0] req_rs2,
    input  logic [15:0]   req_imm,
    input  logic [DW-1:0] op1,
    input  logic [DW-1:0] op2,
    output logic [AW-1:0] sel_o1,
    output logic [AW-1:0] sel_o2,
    output logic          RD,
    output logic [DW-1:0] Ip1,
    output logic [AW-1:0] sel_i1,
    output logic          WR,
    output logic          EN,
    output logic          done,
    output logic          err,
    output logic          zero
);
    localparam int SW = $clog2(DW);
    localparam int CW = $clog2(MUL_ITER);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_SLT = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;
    localparam logic [3:0] OP_LDI = 4'd10;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPT, S_MUL, S_WB, S_ERR} state_t;

    state_t        state_reg, state_next;
    logic [3:0]    op_reg, op_next;
    logic [AW-1:0] rd_reg, rd_next;
    logic [DW-1:0] a_reg, a_next;
    logic [DW-1:0] b_reg, b_next;
    logic [DW-1:0] acc_reg, acc_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    logic          ready_reg, ready_next;
    logic [AW-1:0] sel_o1_reg, sel_o1_next;
    logic [AW-1:0] sel_o2_reg, sel_o2_next;
    logic          rd_strobe_reg, rd_strobe_next;
    logic [DW-1:0] ip1_reg, ip1_next;
    logic [AW-1:0] sel_i1_reg, sel_i1_next;
    logic          wr_reg, wr_next;
    logic          done_reg, done_next;
    logic          err_reg, err_next;
    logic          zero_reg, zero_next;

    logic [DW-1:0] alu_result;
    logic [DW-1:0] mul_sum;

    // Register file data is live during CAPT, so the ALU works straight off op1/op2.
    always_comb begin
        alu_result = '0;
        case (op_reg)
            OP_ADD:  alu_result = op1 + op2;
            OP_SUB:  alu_result = op1 - op2;
            OP_AND:  alu_result = op1 & op2;
            OP_OR:   alu_result = op1 | op2;
            OP_XOR:  alu_result = op1 ^ op2;
            OP_SLL:  alu_result = op1 << op2[SW-1:0];
            OP_SRL:  alu_result = op1 >> op2[SW-1:0];
            OP_SRA:  alu_result = $signed(op1) >>> op2[SW-1:0];
            OP_SLT:  alu_result = {{(DW-1){1'b0}}, ($signed(op1) < $signed(op2))};
            default: alu_result = '0;
        endcase
    end

    assign mul_sum = b_reg[0] ? (acc_reg + a_reg) : acc_reg;

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        rd_next    = rd_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        ip1_next   = ip1_reg;
        case (state_reg)
            S_IDLE: begin
                if (req_valid && ready_reg) begin
                    op_next = req_op;
                    rd_next = req_rd;
                    if (req_op == OP_LDI) begin
                        ip1_next   = {{(DW-16){1'b0}}, req_imm};
                        state_next = S_WB;
                    end else if (req_op > OP_LDI) begin
                        state_next = S_ERR;
                    end else begin
                        state_next = S_READ;
                    end
                end
            end
            S_READ: state_next = S_CAPT;
            S_CAPT: begin
                a_next = op1;
                b_next = op2;
                if (op_reg == OP_MUL) begin
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = S_MUL;
                end else begin
                    ip1_next   = alu_result;
                    state_next = S_WB;
                end
            end
            S_MUL: begin
                acc_next = mul_sum;
                a_next   = a_reg << 1;
                b_next   = b_reg >> 1;
                cnt_next = cnt_reg + CW'(1);
                if (cnt_reg == CW'(MUL_ITER - 1)) begin
                    ip1_next   = mul_sum;
                    state_next = S_WB;
                end
            end
            S_WB:    state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered yet state-aligned.
        ready_next     = (state_next == S_IDLE);
        rd_strobe_next = (state_next == S_READ);
        sel_o1_next    = rd_strobe_next ? req_rs1 : '0;
        sel_o2_next    = rd_strobe_next ? req_rs2 : '0;
        wr_next        = (state_next == S_WB);
        sel_i1_next    = wr_next ? rd_next : '0;
        done_next      = wr_next;
        err_next       = (state_next == S_ERR);
        zero_next      = wr_next ? (ip1_next == '0) : zero_reg;
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            op_reg        <= '0;
            rd_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            ready_reg     <= 1'b1;
            sel_o1_reg    <= '0;
            sel_o2_reg    <= '0;
            rd_strobe_reg <= 1'b0;
            ip1_reg       <= '0;
            sel_i1_reg    <= '0;
            wr_reg        <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            zero_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            op_reg        <= op_next;
            rd_reg        <= rd_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            ready_reg     <= ready_next;
            sel_o1_reg    <= sel_o1_next;
            sel_o2_reg    <= sel_o2_next;
            rd_strobe_reg <= rd_strobe_next;
            ip1_reg       <= ip1_next;
            sel_i1_reg    <= sel_i1_next;
            wr_reg        <= wr_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            zero_reg      <= zero_next;
        end
    end

    assign req_ready = ready_reg;
    assign sel_o1    = sel_o1_reg;
    assign sel_o2    = sel_o2_reg;
    assign RD        = rd_strobe_reg;
    assign Ip1       = ip1_reg;
    assign sel_i1    = sel_i1_reg;
    assign WR        = wr_reg;
    assign EN        = rd_strobe_reg | wr_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_regfile_exec_unit.sv
// Directed bench for regfile_exec_unit with a behavioural 16x32 register file attached.
module tb_regfile_exec_unit;
    localparam int DW = 32;
    localparam int AW = 4;

    logic          CLK = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_op;
    logic [AW-1:0] req_rd, req_rs1, req_rs2;
    logic [15:0]   req_imm;
    logic [DW-1:0] op1 = '0;
    logic [DW-1:0] op2 = '0;
    logic [AW-1:0] sel_o1, sel_o2, sel_i1;
    logic          RD, WR, EN, done, err, zero;
    logic [DW-1:0] Ip1;

    logic [DW-1:0] regs [16] = '{default: '0};

    int vectors     = 0;
    int miscompares = 0;
    int n_issued    = 0;
    int accepts     = 0;
    int n_done      = 0;
    int n_err       = 0;
    bit overlap     = 1'b0;
    int done_snap;

    always #5 CLK = ~CLK;

    regfile_exec_unit #(.DW(DW), .AW(AW), .MUL_ITER(32)) dut (
        .CLK(CLK), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .op1(op1), .op2(op2), .sel_o1(sel_o1), .sel_o2(sel_o2), .RD(RD),
        .Ip1(Ip1), .sel_i1(sel_i1), .WR(WR), .EN(EN),
        .done(done), .err(err), .zero(zero)
    );

    // Register file: read data appears the cycle after an RD edge; writes land on the WR edge.
    always @(posedge CLK) begin
        if (EN && RD) begin
            op1 <= regs[sel_o1];
            op2 <= regs[sel_o2];
        end
        if (EN && WR) regs[sel_i1] <= Ip1;
    end

    always @(posedge CLK) begin
        if (req_valid && req_ready) accepts <= accepts + 1;
        if (done) n_done <= n_done + 1;
        if (err)  n_err  <= n_err + 1;
    end

    always @(negedge CLK) begin
        if (RD && WR) overlap <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Leaves req_valid high (busy-time hold) and returns at the negedge of cycle 1 after accept.
    task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                         input logic [3:0] rs2, input logic [15:0] imm);
        int w = 0;
        while (!req_ready && w < 100) begin
            @(negedge CLK);
            w++;
        end
        chk("ready_wait", 32'(req_ready), 32'd1);
        req_op    = op;
        req_rd    = rd;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_imm   = imm;
        req_valid = 1'b1;
        n_issued++;
        @(posedge CLK);
        @(negedge CLK);
        chk("ready_drop", 32'(req_ready), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [3:0] rd,
                          input logic [3:0] rs1, input logic [3:0] rs2, input logic [15:0] imm,
                          input int exp_lat, input bit exp_err);
        int n = 1;
        issue(op, rd, rs1, rs2, imm);
        if (!exp_err && exp_lat > 1) begin
            chk({tag, "_rd"}, 32'(RD), 32'd1);
            chk({tag, "_sel_o1"}, 32'(sel_o1), 32'(rs1));
        end
        while (!(done || err) && n < 60) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
        if (exp_err) begin
            chk({tag, "_err"}, 32'(err), 32'd1);
            chk({tag, "_no_done"}, 32'(done), 32'd0);
            chk({tag, "_no_wr"}, 32'(WR), 32'd0);
        end else begin
            chk({tag, "_done"}, 32'(done), 32'd1);
            chk({tag, "_wr"}, 32'(WR), 32'd1);
            chk({tag, "_sel_i1"}, 32'(sel_i1), 32'(rd));
        end
        req_valid = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_rd = '0;
        req_rs1 = '0; req_rs2 = '0; req_imm = '0;
        repeat (2) @(negedge CLK);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_strobes", {27'd0, RD, WR, EN, done, err}, 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_ip1", Ip1, 32'd0);
        rst = 1'b0;
        @(negedge CLK);

        run_op("ldi_r0", 4'd10, 4'd0, 4'd0, 4'd0, 16'hABCD, 1, 1'b0);
        chk("ldi_r0_val", regs[0], 32'h0000ABCD);
        run_op("ldi_r1", 4'd10, 4'd1, 4'd0, 4'd0, 16'h4567, 1, 1'b0);
        chk("ldi_r1_val", regs[1], 32'h00004567);
        run_op("add_r2", 4'd0, 4'd2, 4'd0, 4'd1, 16'h0, 3, 1'b0);
        chk("add_r2_val", regs[2], 32'h0000F134);
        chk("add_r2_zero", 32'(zero), 32'd0);
        run_op("ldi_r5", 4'd10, 4'd5, 4'd0, 4'd0, 16'h0001, 1, 1'b0);
        run_op("sub_r3", 4'd1, 4'd3, 4'd4, 4'd5, 16'h0, 3, 1'b0);
        chk("sub_r3_val", regs[3], 32'hFFFFFFFF);
        run_op("sra_r6", 4'd7, 4'd6, 4'd3, 4'd5, 16'h0, 3, 1'b0);
        chk("sra_r6_val", regs[6], 32'hFFFFFFFF);
        run_op("srl_r12", 4'd6, 4'd12, 4'd3, 4'd5, 16'h0, 3, 1'b0);
        chk("srl_r12_val", regs[12], 32'h7FFFFFFF);
        run_op("slt_r7", 4'd8, 4'd7, 4'd3, 4'd4, 16'h0, 3, 1'b0);
        chk("slt_r7_val", regs[7], 32'h00000001);
        run_op("slt_r11", 4'd8, 4'd11, 4'd4, 4'd3, 16'h0, 3, 1'b0);
        chk("slt_r11_val", regs[11], 32'h00000000);
        chk("slt_r11_zero", 32'(zero), 32'd1);
        run_op("sll_r13", 4'd5, 4'd13, 4'd1, 4'd5, 16'h0, 3, 1'b0);
        chk("sll_r13_val", regs[13], 32'h00008ACE);
        run_op("and_r14", 4'd2, 4'd14, 4'd0, 4'd1, 16'h0, 3, 1'b0);
        chk("and_r14_val", regs[14], 32'h00000145);
        run_op("or_r15", 4'd3, 4'd15, 4'd0, 4'd1, 16'h0, 3, 1'b0);
        chk("or_r15_val", regs[15], 32'h0000EFEF);
        run_op("mul_r8", 4'd9, 4'd8, 4'd0, 4'd1, 16'h0, 35, 1'b0);
        chk("mul_r8_val", regs[8], 32'h2E93607B);
        run_op("mul_r3", 4'd9, 4'd3, 4'd3, 4'd3, 16'h0, 35, 1'b0);
        chk("mul_r3_val", regs[3], 32'h00000001);
        run_op("illegal", 4'd12, 4'd2, 4'd0, 4'd1, 16'h0, 1, 1'b1);
        chk("illegal_r2_kept", regs[2], 32'h0000F134);
        run_op("xor_r9", 4'd4, 4'd9, 4'd0, 4'd0, 16'h0, 3, 1'b0);
        chk("xor_r9_val", regs[9], 32'h00000000);
        chk("xor_r9_zero", 32'(zero), 32'd1);
        run_op("add_r10", 4'd0, 4'd10, 4'd9, 4'd1, 16'h0, 3, 1'b0);
        chk("add_r10_val", regs[10], 32'h00004567);
        chk("add_r10_zero", 32'(zero), 32'd0);

        // Abort a multiply ten cycles into its iterations.
        issue(4'd9, 4'd11, 4'd0, 4'd1, 16'h0);
        req_valid = 1'b0;
        repeat (11) @(negedge CLK);
        done_snap = n_done;
        rst = 1'b1;
        #1;
        chk("abort_strobes", {28'd0, RD, WR, EN, done}, 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        @(negedge CLK);
        rst = 1'b0;
        repeat (40) @(negedge CLK);
        chk("abort_ready_after", 32'(req_ready), 32'd1);
        chk("abort_r11_kept", regs[11], 32'h00000000);
        chk("abort_no_done", 32'(n_done), 32'(done_snap));

        chk("accept_count", 32'(accepts), 32'(n_issued));
        chk("completion_count", 32'(n_done + n_err), 32'(n_issued - 1));
        chk("err_count", 32'(n_err), 32'd1);
        chk("rd_wr_overlap", 32'(overlap), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
